// File: rtl/fbe_pkg.sv
// Shared definitions for the frame backlight estimator: metric selects,
// controller states and the accumulator width rule.
package fbe_pkg;

    localparam logic [1:0] MODE_MAX   = 2'd0;
    localparam logic [1:0] MODE_MEAN  = 2'd1;
    localparam logic [1:0] MODE_BLEND = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVIDE  = 2'd1,
        SMOOTH  = 2'd2,
        PUBLISH = 2'd3
    } fbe_state_e;

    // The sum accumulator must hold a full-scale value for every countable pixel.
    function automatic int sum_width(input int lin_w, input int cnt_w);
        return lin_w + cnt_w;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; start loads operands, done
// pulses for one cycle once the quotient is final. Division by zero yields 0.
module seq_divider #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 22
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  done_o,
    output logic [DIVIDEND_W-1:0] quotient_o
);

    localparam int CW = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  div_q, div_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  zero_q, zero_d;

    logic [DIVISOR_W:0]    rem_sh;
    logic [DIVISOR_W:0]    rem_diff;
    logic                  ge;

    always_comb begin
        rem_sh   = {rem_q, quo_q[DIVIDEND_W-1]};
        rem_diff = rem_sh - {1'b0, div_q};
        ge       = (rem_sh >= {1'b0, div_q});

        quo_d  = quo_q;
        rem_d  = rem_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        zero_d = zero_q;

        if (start_i) begin
            quo_d  = dividend_i;
            rem_d  = '0;
            div_d  = divisor_i;
            cnt_d  = CW'(DIVIDEND_W);
            busy_d = 1'b1;
            zero_d = (divisor_i == '0);
        end else if (busy_q) begin
            quo_d = {quo_q[DIVIDEND_W-2:0], ge};
            rem_d = ge ? DIVISOR_W'(rem_diff) : DIVISOR_W'(rem_sh);
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quo_q  <= '0;
            rem_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            zero_q <= zero_d;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = zero_q ? '0 : quo_q;

endmodule

// File: rtl/frame_backlight_estimator.sv
// Per-frame max/mean luminance statistics with IIR-smoothed, floored backlight output.
//  state   | meaning
//  IDLE    | accumulating, waiting for a frame end
//  DIVIDE  | sequential sum/count divide of the held frame
//  SMOOTH  | metric select, floor and IIR step; result registered
//  PUBLISH | new level/statistics visible, level_valid high
module frame_backlight_estimator
    import fbe_pkg::*;
#(
    parameter int NUM_CH       = 3,
    parameter int LIN_W        = 10,
    parameter int PWM_W        = 10,
    parameter int CNT_W        = 22,
    parameter int MODE         = 0,
    parameter int SMOOTH_SHIFT = 2,
    parameter int MIN_LEVEL    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*LIN_W-1:0] pix_lin,
    input  logic                    de,
    input  logic                    vsync,
    input  logic [1:0]              mode_sel,
    input  logic                    bl_enable,
    output logic [PWM_W-1:0]        backlight_level,
    output logic                    level_valid,
    output logic [LIN_W-1:0]        frame_peak,
    output logic [LIN_W-1:0]        frame_mean,
    output logic                    busy,
    output logic [7:0]              overrun_count
);

    localparam int               SUM_W   = sum_width(LIN_W, CNT_W);
    localparam logic [LIN_W-1:0] LIN_MAX = '1;
    localparam logic [LIN_W-1:0] MIN_LVL = LIN_W'(MIN_LEVEL);

    fbe_state_e state_q, state_d;

    logic                vsync_q;
    logic [LIN_W-1:0]    acc_max_q, acc_max_d;
    logic [SUM_W-1:0]    acc_sum_q, acc_sum_d;
    logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
    logic [LIN_W-1:0]    hold_max_q, hold_max_d;
    logic [1:0]          sel_q, sel_d;
    logic [LIN_W-1:0]    lvl_q, lvl_d;
    logic                first_q, first_d;
    logic [LIN_W-1:0]    peak_q, peak_d;
    logic [LIN_W-1:0]    mean_q, mean_d;
    logic [PWM_W-1:0]    bl_q, bl_d;
    logic [7:0]          ovr_q, ovr_d;

    logic                frame_end;
    logic                div_start;
    logic                div_done;
    logic [SUM_W-1:0]    quo;
    logic [LIN_W-1:0]    pmax;
    logic [LIN_W-1:0]    pix_val;
    logic [SUM_W:0]      sum_ext;

    logic [LIN_W-1:0]    mean_clamp, blend, metric, target, lvl_next;
    logic [LIN_W:0]      blend_sum;
    logic signed [LIN_W:0] diff, step, lvl_sum;
    logic [PWM_W-1:0]    lvl_scaled;

    assign frame_end = vsync & ~vsync_q;

    always_comb begin
        pmax = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (pix_lin[c*LIN_W +: LIN_W] > pmax) pmax = pix_lin[c*LIN_W +: LIN_W];
        end
    end

    // A de pixel coinciding with the frame end opens the next frame.
    always_comb begin
        pix_val   = de ? pmax : '0;
        sum_ext   = {1'b0, acc_sum_q} + (SUM_W+1)'(pmax);
        acc_max_d = acc_max_q;
        acc_sum_d = acc_sum_q;
        acc_cnt_d = acc_cnt_q;
        if (frame_end) begin
            acc_max_d = pix_val;
            acc_sum_d = SUM_W'(pix_val);
            acc_cnt_d = de ? CNT_W'(1) : '0;
        end else if (de) begin
            acc_max_d = (pmax > acc_max_q) ? pmax : acc_max_q;
            acc_sum_d = sum_ext[SUM_W] ? '1 : SUM_W'(sum_ext);
            acc_cnt_d = (&acc_cnt_q) ? acc_cnt_q : acc_cnt_q + CNT_W'(1);
        end
    end

    seq_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W)
    ) u_div (
        .clk_i      (clk),
        .rst_ni     (reset),
        .start_i    (div_start),
        .dividend_i (acc_sum_q),
        .divisor_i  (acc_cnt_q),
        .done_o     (div_done),
        .quotient_o (quo)
    );

    always_comb begin
        mean_clamp = (quo > SUM_W'(LIN_MAX)) ? LIN_MAX : LIN_W'(quo);
        blend_sum  = {1'b0, hold_max_q} + {1'b0, mean_clamp};
        blend      = LIN_W'(blend_sum >> 1);
        case (sel_q)
            MODE_MAX:   metric = hold_max_q;
            MODE_MEAN:  metric = mean_clamp;
            MODE_BLEND: metric = blend;
            default:    metric = hold_max_q;
        endcase
        target = (metric < MIN_LVL) ? MIN_LVL : metric;
        diff   = $signed({1'b0, target}) - $signed({1'b0, lvl_q});
        step   = diff >>> SMOOTH_SHIFT;
        // Never stall short of the target once the shifted step rounds to zero.
        if (step == '0 && diff != '0) step = diff[LIN_W] ? '1 : (LIN_W+1)'(1);
        lvl_sum  = $signed({1'b0, lvl_q}) + step;
        lvl_next = first_q ? target : LIN_W'(lvl_sum);
    end

    if (PWM_W >= LIN_W) begin : g_scale_up
        assign lvl_scaled = PWM_W'(lvl_next) << (PWM_W - LIN_W);
    end else begin : g_scale_dn
        assign lvl_scaled = lvl_next[LIN_W-1 -: PWM_W];
    end

    always_comb begin
        hold_max_d = hold_max_q;
        sel_d      = sel_q;
        lvl_d      = lvl_q;
        first_d    = first_q;
        peak_d     = peak_q;
        mean_d     = mean_q;
        bl_d       = bl_q;
        ovr_d      = ovr_q;
        if (frame_end) begin
            if (state_q == IDLE) begin
                hold_max_d = acc_max_q;
                sel_d      = (mode_sel == 2'd3) ? 2'(MODE) : mode_sel;
            end else if (ovr_q != 8'hFF) begin
                ovr_d = ovr_q + 8'd1;
            end
        end
        if (state_q == SMOOTH) begin
            lvl_d   = lvl_next;
            first_d = 1'b0;
            peak_d  = hold_max_q;
            mean_d  = mean_clamp;
            bl_d    = bl_enable ? lvl_scaled : '1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_end) state_d = DIVIDE;
            DIVIDE:  if (div_done)  state_d = SMOOTH;
            SMOOTH:  state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        level_valid = (state_q == PUBLISH);
        div_start   = frame_end && (state_q == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q    <= 1'b0;
            acc_max_q  <= '0;
            acc_sum_q  <= '0;
            acc_cnt_q  <= '0;
            hold_max_q <= '0;
            sel_q      <= '0;
            lvl_q      <= '0;
            first_q    <= 1'b1;
            peak_q     <= '0;
            mean_q     <= '0;
            bl_q       <= '1;
            ovr_q      <= '0;
        end else begin
            vsync_q    <= vsync;
            acc_max_q  <= acc_max_d;
            acc_sum_q  <= acc_sum_d;
            acc_cnt_q  <= acc_cnt_d;
            hold_max_q <= hold_max_d;
            sel_q      <= sel_d;
            lvl_q      <= lvl_d;
            first_q    <= first_d;
            peak_q     <= peak_d;
            mean_q     <= mean_d;
            bl_q       <= bl_d;
            ovr_q      <= ovr_d;
        end
    end

    assign backlight_level = bl_q;
    assign frame_peak      = peak_q;
    assign frame_mean      = mean_q;
    assign overrun_count   = ovr_q;

endmodule

// File: tb/tb_frame_backlight_estimator.sv
// Directed frames with hand-computed results; a monitor scores every level_valid pulse.
module tb_frame_backlight_estimator;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] pix_lin;
    logic        de;
    logic        vsync;
    logic [1:0]  mode_sel;
    logic        bl_enable;
    logic [9:0]  backlight_level;
    logic        level_valid;
    logic [9:0]  frame_peak;
    logic [9:0]  frame_mean;
    logic        busy;
    logic [7:0]  overrun_count;

    frame_backlight_estimator dut (
        .clk             (clk),
        .reset           (reset),
        .pix_lin         (pix_lin),
        .de              (de),
        .vsync           (vsync),
        .mode_sel        (mode_sel),
        .bl_enable       (bl_enable),
        .backlight_level (backlight_level),
        .level_valid     (level_valid),
        .frame_peak      (frame_peak),
        .frame_mean      (frame_mean),
        .busy            (busy),
        .overrun_count   (overrun_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int peak;
        int mean;
        int level;
        int ecyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (reset && level_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_level_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_peak", int'(frame_peak), e.peak);
                check("frame_mean", int'(frame_mean), e.mean);
                check("backlight_level", int'(backlight_level), e.level);
                check("latency", cyc - e.ecyc, 35);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input int r, input int g, input int b);
        pix_lin = {10'(r), 10'(g), 10'(b)};
        de = 1'b1;
        tick();
        de = 1'b0;
        pix_lin = '0;
    endtask

    task automatic frame4();
        px(100, 200, 50);
        px(300, 10, 10);
        px(0, 0, 0);
        px(50, 50, 700);
    endtask

    task automatic end_frame(input int peak, input int mean, input int level);
        vsync = 1'b1;
        exp_q.push_back('{peak, mean, level, cyc});
        tick();
        check("busy_after_frame_end", int'(busy), 1);
        tick();
        vsync = 1'b0;
        repeat (40) tick();
        check("busy_back_idle", int'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset     = 1'b0;
        pix_lin   = '0;
        de        = 1'b0;
        vsync     = 1'b0;
        mode_sel  = 2'd0;
        bl_enable = 1'b1;
        tick();
        tick();
        check("reset_level", int'(backlight_level), 1023);
        check("reset_valid", int'(level_valid), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_peak", int'(frame_peak), 0);
        check("reset_mean", int'(frame_mean), 0);
        check("reset_overrun", int'(overrun_count), 0);
        reset = 1'b1;
        repeat (3) tick();

        // mode_sel 3 falls back to the MODE parameter (max)
        mode_sel = 2'd3;
        frame4();
        end_frame(700, 300, 700);
        mode_sel = 2'd0;
        px(300, 0, 0);
        end_frame(300, 300, 600);
        px(300, 0, 0);
        end_frame(300, 300, 525);

        do_reset();
        mode_sel = 2'd1;
        frame4();
        end_frame(700, 300, 300);

        do_reset();
        mode_sel = 2'd2;
        frame4();
        end_frame(700, 300, 500);

        do_reset();
        mode_sel = 2'd0;
        end_frame(0, 0, 16);

        // second frame end lands while the first is still dividing
        do_reset();
        frame4();
        vsync = 1'b1;
        exp_q.push_back('{700, 300, 700, cyc});
        tick();
        tick();
        vsync = 1'b0;
        repeat (8) tick();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        repeat (40) tick();
        check("overrun_count", int'(overrun_count), 1);

        // reset during DIVIDE: no pulse, immediate return to reset values
        frame4();
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check("midreset_level", int'(backlight_level), 1023);
        check("midreset_peak", int'(frame_peak), 0);
        check("midreset_mean", int'(frame_mean), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_overrun", int'(overrun_count), 0);
        check("midreset_valid", int'(level_valid), 0);
        tick();
        reset = 1'b1;
        repeat (45) tick();

        // disabled backlight forces full scale but the level still tracks
        bl_enable = 1'b0;
        frame4();
        end_frame(700, 300, 1023);
        bl_enable = 1'b1;
        px(300, 0, 0);
        end_frame(300, 300, 600);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
